// File: rtl/pooling_output_buffer.sv
// rtl/pooling_output_buffer.sv - result capture, tagging and FWFT queue behind the pooling array
//
// Keeps only the final 2x2 maxima that arrive on odd feature rows. Each kept value is
// tagged with feature, pooled row and pooled column, then held in a small
// first-word-fall-through queue. The queue drains to the next layer over valid/ready.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           synchronous flush of queue, column counter and sticky flags
//   data_in         pooling array result
//   feature_idx     feature of data_in
//   feature_row     source row of data_in (odd rows carry final results)
//   input_valid     pooling array output_valid
//   data_out        head-of-queue pooled value
//   out_feature     feature of data_out
//   out_row         pooled row (feature_row >> 1)
//   out_col         pooled column
//   out_last        head entry closes the frame
//   output_valid    head entry present
//   output_ready    consumer accepts the head
//   overflow        sticky, a result was dropped on a full queue
//   frame_done      one-cycle pulse after the last entry of the frame is popped

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module pooling_output_buffer #(
  parameter int TOTAL_FEATURE = 4,
  parameter int FEATURE_WIDTH = 2,
  parameter int ROW_WIDTH     = 3,
  parameter int OUT_COLS      = 3,
  parameter int COL_WIDTH     = 2,
  parameter int OUT_ROWS      = 3,
  parameter int DEPTH         = 8,
  parameter int PTR_WIDTH     = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic [`DATA_WIDTH-1:0]   data_in,
  input  logic [FEATURE_WIDTH-1:0] feature_idx,
  input  logic [ROW_WIDTH-1:0]     feature_row,
  input  logic                     input_valid,
  output logic [`DATA_WIDTH-1:0]   data_out,
  output logic [FEATURE_WIDTH-1:0] out_feature,
  output logic [ROW_WIDTH-2:0]     out_row,
  output logic [COL_WIDTH-1:0]     out_col,
  output logic                     out_last,
  output logic                     output_valid,
  input  logic                     output_ready,
  output logic                     overflow,
  output logic                     frame_done
);

  localparam logic [FEATURE_WIDTH-1:0] LAST_FEATURE = FEATURE_WIDTH'(TOTAL_FEATURE - 1);
  localparam logic [COL_WIDTH-1:0]     LAST_COL     = COL_WIDTH'(OUT_COLS - 1);
  localparam logic [ROW_WIDTH-2:0]     LAST_ROW     = (ROW_WIDTH-1)'(OUT_ROWS - 1);
  localparam logic [PTR_WIDTH:0]       FULL_COUNT   = (PTR_WIDTH+1)'(DEPTH);

  // Queue storage, one array per tag field
  logic [`DATA_WIDTH-1:0]   mem_data    [DEPTH];
  logic [FEATURE_WIDTH-1:0] mem_feature [DEPTH];
  logic [ROW_WIDTH-2:0]     mem_row     [DEPTH];
  logic [COL_WIDTH-1:0]     mem_col     [DEPTH];
  logic                     mem_last    [DEPTH];

  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH:0]   count;
  logic [COL_WIDTH-1:0] col_cnt;

  logic                 push_req;
  logic                 push_ok;
  logic                 drop;
  logic                 pop;
  logic                 full;
  logic [ROW_WIDTH-2:0] pooled_row;
  logic                 entry_last;

  // Even rows only carry the upper half of the vertical window; they are ignored.
  assign push_req   = input_valid && feature_row[0];
  assign pooled_row = feature_row[ROW_WIDTH-1:1];
  assign full       = (count == FULL_COUNT);
  assign pop        = output_valid && output_ready;
  // A full queue still accepts when the head leaves in the same cycle.
  assign push_ok    = push_req && (!full || pop);
  assign drop       = push_req && full && !pop;
  assign entry_last = (feature_idx == LAST_FEATURE) && (col_cnt == LAST_COL) &&
                      (pooled_row == LAST_ROW);

  // Storage: cleared on reset so the head fields read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i]    <= '0;
        mem_feature[i] <= '0;
        mem_row[i]     <= '0;
        mem_col[i]     <= '0;
        mem_last[i]    <= 1'b0;
      end
    end else if (!clear && push_ok) begin
      mem_data[wr_ptr]    <= data_in;
      mem_feature[wr_ptr] <= feature_idx;
      mem_row[wr_ptr]     <= pooled_row;
      mem_col[wr_ptr]     <= col_cnt;
      mem_last[wr_ptr]    <= entry_last;
    end
  end

  // Pointers, occupancy and column tracking; clear outranks push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      col_cnt <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      col_cnt <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // The column closes once its last feature has actually been stored.
      if (push_ok && (feature_idx == LAST_FEATURE)) begin
        col_cnt <= (col_cnt == LAST_COL) ? '0 : col_cnt + 1'b1;
      end
    end
  end

  // Sticky overflow and end-of-frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else if (clear) begin
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end
      frame_done <= pop && mem_last[rd_ptr];
    end
  end

  // Fall-through head: fields come straight from the entry at the read pointer.
  assign output_valid = (count != '0);
  assign data_out     = mem_data[rd_ptr];
  assign out_feature  = mem_feature[rd_ptr];
  assign out_row      = mem_row[rd_ptr];
  assign out_col      = mem_col[rd_ptr];
  assign out_last     = mem_last[rd_ptr];

endmodule

// File: tb/tb_pooling_output_buffer.sv
// tb/tb_pooling_output_buffer.sv - randomized and directed bench for pooling_output_buffer

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_pooling_output_buffer;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [31:0] data_in;
  logic [1:0]  feature_idx;
  logic [2:0]  feature_row;
  logic        input_valid;
  logic [31:0] data_out;
  logic [1:0]  out_feature;
  logic [1:0]  out_row;
  logic [1:0]  out_col;
  logic        out_last;
  logic        output_valid;
  logic        output_ready;
  logic        overflow;
  logic        frame_done;

  pooling_output_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .data_in      (data_in),
    .feature_idx  (feature_idx),
    .feature_row  (feature_row),
    .input_valid  (input_valid),
    .data_out     (data_out),
    .out_feature  (out_feature),
    .out_row      (out_row),
    .out_col      (out_col),
    .out_last     (out_last),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .overflow     (overflow),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          f;
    int          r;
    int          c;
    bit          l;
  } ent_t;

  // Reference model: a plain queue of tagged results plus frame bookkeeping.
  ent_t q[$];
  int   m_col;
  bit   m_ovf;
  bit   m_fd;
  int   fd_pulses;

  int vectors;
  int miscompares;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_col = 0;
    m_ovf = 0;
    m_fd  = 0;
  endtask

  task automatic compare_outputs();
    check("output_valid", 64'(output_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      check("data_out",    64'(data_out),    64'(q[0].d));
      check("out_feature", 64'(out_feature), 64'(q[0].f));
      check("out_row",     64'(out_row),     64'(q[0].r));
      check("out_col",     64'(out_col),     64'(q[0].c));
      check("out_last",    64'(out_last),    64'(q[0].l));
    end
    check("overflow",   64'(overflow),   64'(m_ovf));
    check("frame_done", 64'(frame_done), 64'(m_fd));
    if (frame_done) fd_pulses++;
  endtask

  // One clock: drive inputs, compare current outputs, advance the model, step the clock.
  task automatic cycle(input bit v, input int feat, input int row, input logic [31:0] d,
                       input bit rdy, input bit clr);
    bit   pop, req, accept;
    ent_t e;
    input_valid  = v;
    feature_idx  = 2'(feat);
    feature_row  = 3'(row);
    data_in      = d;
    output_ready = rdy;
    clear        = clr;
    #1;
    compare_outputs();
    pop = (q.size() != 0) && rdy;
    req = v && (row % 2 == 1);
    if (clr) begin
      model_reset();
    end else begin
      m_fd = pop && q[0].l;
      accept = req && (q.size() < 8 || pop);
      if (pop) void'(q.pop_front());
      if (accept) begin
        e.d = d;
        e.f = feat;
        e.r = row / 2;
        e.c = m_col;
        e.l = (feat == 3) && (m_col == 2) && (row / 2 == 2);
        q.push_back(e);
        if (feat == 3) m_col = (m_col + 1) % 3;
      end
      if (req && !accept) m_ovf = 1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 32'h0, rdy, 0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    fd_pulses   = 0;
    model_reset();
    rst_n        = 1'b0;
    clear        = 1'b0;
    input_valid  = 1'b0;
    feature_idx  = '0;
    feature_row  = '0;
    data_in      = '0;
    output_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst data_out",    64'(data_out),    64'h0);
    check("rst out_feature", 64'(out_feature), 64'h0);
    check("rst out_row",     64'(out_row),     64'h0);
    check("rst out_col",     64'(out_col),     64'h0);
    check("rst out_last",    64'(out_last),    64'h0);
    idle(3, 1);

    // Even-row filtering, then the odd row of the same window
    for (int f = 0; f < 4; f++) cycle(1, f, 0, 32'hDEAD0000 + 32'(f), 1, 0);
    idle(1, 1);
    begin
      logic [31:0] vals [4];
      vals[0] = 32'h3F800000; vals[1] = 32'h40000000;
      vals[2] = 32'h40400000; vals[3] = 32'h40800000;
      for (int f = 0; f < 4; f++) cycle(1, f, 1, vals[f], 1, 0);
    end
    idle(3, 1);

    // Whole frame: rows 1,3,5 x 3 columns x 4 features, consumer always ready
    cycle(0, 0, 0, 0, 1, 1);
    fd_pulses = 0;
    for (int r = 1; r <= 5; r += 2)
      for (int c = 0; c < 3; c++)
        for (int f = 0; f < 4; f++)
          cycle(1, f, r, $urandom, 1, 0);
    idle(4, 1);
    check("frame_done pulses", 64'(fd_pulses), 64'd1);

    // Backpressure: nine pushes into eight slots
    cycle(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 9; i++) cycle(1, i % 4, 3, 32'h1000 + 32'(i), 0, 0);
    check("overflow after 9", 64'(overflow), 64'h1);
    idle(10, 1);
    check("overflow sticky", 64'(overflow), 64'h1);
    cycle(0, 0, 0, 0, 1, 1);
    check("overflow cleared", 64'(overflow), 64'h0);

    // Full queue with a push and a pop in the same cycle
    for (int i = 0; i < 8; i++) cycle(1, i % 4, 1, 32'h2000 + 32'(i), 0, 0);
    cycle(1, 1, 1, 32'h2FFF, 1, 0);
    check("no overflow on push+pop", 64'(overflow), 64'h0);
    idle(9, 1);

    // Mid-stream flush with a push in the clear cycle, then col restarts at 0
    cycle(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) cycle(1, 3, 1, 32'h3000 + 32'(i), 0, 0);
    cycle(1, 3, 1, 32'h3FFF, 0, 1);
    check("valid after clear", 64'(output_valid), 64'h0);
    cycle(1, 0, 1, 32'h3ABC, 0, 0);
    check("col after clear", 64'(out_col), 64'h0);
    idle(2, 1);

    // Asynchronous reset mid-frame
    for (int i = 0; i < 4; i++) cycle(1, i, 5, 32'h4000 + 32'(i), 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst valid",      64'(output_valid), 64'h0);
    check("async rst frame_done", 64'(frame_done),   64'h0);
    check("async rst data_out",   64'(data_out),     64'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2, 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 7),
            $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0);
    end
    idle(10, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
